// File: rtl/enigma_cfg_pkg.sv
// Shared opcodes, FSM states and factory constants for the Enigma configuration bank.
package enigma_cfg_pkg;

    localparam int unsigned ALPHA       = 26;
    localparam int unsigned MAX_PAIRS   = 13;
    localparam int unsigned ROTOR_COUNT = 5;
    localparam int unsigned PLUG_W      = 5 * ALPHA;

    localparam logic [4:0] FACTORY_RING  = 5'd0;
    localparam logic [4:0] FACTORY_GRUND = 5'd0;
    localparam logic [4:0] FACTORY_PAIRS = 5'd0;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_SET_ROTOR = 4'd1,
        OP_SET_RING  = 4'd2,
        OP_SET_GRUND = 4'd3,
        OP_PLUG_ADD  = 4'd4,
        OP_PLUG_DEL  = 4'd5,
        OP_PLUG_CLR  = 4'd6,
        OP_FACTORY   = 4'd7,
        OP_SAVE      = 4'd8,
        OP_LOAD      = 4'd9,
        OP_LOCK      = 4'd10,
        OP_UNLOCK    = 4'd11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_COPY,
        ST_RESP
    } cfg_state_e;

    // Factory rotor order is simply I, II, III[, IV] from the right.
    function automatic logic [2:0] rotor_factory_id(input int unsigned k);
        return 3'(k);
    endfunction

endpackage

// File: rtl/config_slot_store.sv
// Saved-configuration slots: per-slot scalars, a 26-entry plugboard copy and valid bits.
module config_slot_store
    import enigma_cfg_pkg::*;
#(
    parameter int unsigned NUM_ROTORS = 3,
    parameter int unsigned NUM_SLOTS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              slot,
    input  logic                    scalar_we,
    input  logic [3*NUM_ROTORS-1:0] rotor_wdata,
    input  logic [5*NUM_ROTORS-1:0] ring_wdata,
    input  logic [5*NUM_ROTORS-1:0] grund_wdata,
    input  logic [4:0]              cnt_wdata,
    output logic [3*NUM_ROTORS-1:0] rotor_rdata,
    output logic [5*NUM_ROTORS-1:0] ring_rdata,
    output logic [5*NUM_ROTORS-1:0] grund_rdata,
    output logic [4:0]              cnt_rdata,
    input  logic                    plug_we,
    input  logic [4:0]              plug_idx,
    input  logic [4:0]              plug_wdata,
    output logic [4:0]              plug_rdata,
    input  logic                    set_valid,
    output logic [NUM_SLOTS-1:0]    slot_valid
);
    localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [SW-1:0]             sidx;
    logic [3*NUM_ROTORS-1:0]   rotor_mem [NUM_SLOTS];
    logic [5*NUM_ROTORS-1:0]   ring_mem  [NUM_SLOTS];
    logic [5*NUM_ROTORS-1:0]   grund_mem [NUM_SLOTS];
    logic [4:0]                cnt_mem   [NUM_SLOTS];
    logic [4:0]                plug_mem  [NUM_SLOTS][ALPHA];

    assign sidx = slot[SW-1:0];

    always_ff @(posedge clk) begin
        if (scalar_we) begin
            rotor_mem[sidx] <= rotor_wdata;
            ring_mem[sidx]  <= ring_wdata;
            grund_mem[sidx] <= grund_wdata;
            cnt_mem[sidx]   <= cnt_wdata;
        end
        if (plug_we) begin
            plug_mem[sidx][plug_idx] <= plug_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_valid <= '0;
        end else if (set_valid) begin
            slot_valid[sidx] <= 1'b1;
        end
    end

    always_comb begin
        rotor_rdata = rotor_mem[sidx];
        ring_rdata  = ring_mem[sidx];
        grund_rdata = grund_mem[sidx];
        cnt_rdata   = cnt_mem[sidx];
        plug_rdata  = plug_mem[sidx][plug_idx];
    end

endmodule

// File: rtl/enigma_config_bank.sv
// Live Enigma configuration (rotors, rings, Grundstellung, plugboard) with saved slots.
// Optional write lock is built when CFG_WRITE_LOCK_EN is defined.
module enigma_config_bank
    import enigma_cfg_pkg::*;
#(
    parameter int unsigned NUM_ROTORS = 3,
    parameter int unsigned NUM_SLOTS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_op,
    input  logic [5*NUM_ROTORS-1:0] cmd_data,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [3*NUM_ROTORS-1:0] rotor_sel,
    output logic [5*NUM_ROTORS-1:0] ring,
    output logic [5*NUM_ROTORS-1:0] grund,
    output logic [PLUG_W-1:0]       plug_map,
    output logic [4:0]              plug_pair_cnt,
    output logic                    locked
);
    localparam int unsigned RW = 3 * NUM_ROTORS;
    localparam int unsigned DW = 5 * NUM_ROTORS;

    cfg_state_e    state_q, state_d;
    logic [RW-1:0] rotor_q, rotor_d, factory_rotor;
    logic [DW-1:0] ring_q, ring_d, grund_q, grund_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [4:0]    pm_q [ALPHA];
    logic [4:0]    pm_d [ALPHA];
    logic          rsp_err_q;
    logic [4:0]    copy_idx_q;
    logic          copy_load_q;
    logic [2:0]    copy_slot_q;

    cmd_op_e       op;
    logic [4:0]    pa, pb;
    logic [2:0]    slot;
    logic [7:0]    valid_ext;
    logic          slot_ok, cmd_err, start_copy, lock_block, accept;
    logic          copy_first, copy_last;

    logic [RW-1:0]        st_rotor;
    logic [DW-1:0]        st_ring, st_grund;
    logic [4:0]           st_cnt, st_plug;
    logic [NUM_SLOTS-1:0] slot_valid;
    logic                 st_scalar_we, st_plug_we, st_set_valid;

`ifdef CFG_WRITE_LOCK_EN
    logic locked_q, locked_d;
`endif

    assign op         = cmd_op_e'(cmd_op);
    assign pa         = cmd_data[4:0];
    assign pb         = cmd_data[9:5];
    assign slot       = cmd_data[2:0];
    assign valid_ext  = 8'(slot_valid);
    assign slot_ok    = ({1'b0, slot} < 4'(NUM_SLOTS));
    assign cmd_ready  = (state_q == ST_IDLE) & rst_n;
    assign accept     = cmd_valid & cmd_ready;
    assign copy_first = (copy_idx_q == 5'd0);
    assign copy_last  = (copy_idx_q == 5'(ALPHA - 1));

    always_comb begin
        factory_rotor = '0;
        for (int unsigned k = 0; k < NUM_ROTORS; k++) begin
            factory_rotor[3*k +: 3] = rotor_factory_id(k);
        end
    end

`ifdef CFG_WRITE_LOCK_EN
    always_comb begin
        lock_block = 1'b0;
        if (locked_q) begin
            case (op)
                OP_SET_ROTOR, OP_SET_RING, OP_SET_GRUND, OP_PLUG_ADD,
                OP_PLUG_DEL, OP_PLUG_CLR, OP_FACTORY, OP_LOAD: lock_block = 1'b1;
                default: lock_block = 1'b0;
            endcase
        end
    end
    assign locked = locked_q;
`else
    assign lock_block = 1'b0;
    assign locked     = 1'b0;
`endif

    // Command decode: proposed next live config plus verdict; applied only on accept without error.
    always_comb begin
        rotor_d    = rotor_q;
        ring_d     = ring_q;
        grund_d    = grund_q;
        cnt_d      = cnt_q;
        pm_d       = pm_q;
        cmd_err    = 1'b0;
        start_copy = 1'b0;
`ifdef CFG_WRITE_LOCK_EN
        locked_d   = locked_q;
`endif
        if (lock_block) begin
            cmd_err = 1'b1;
        end else begin
            case (op)
                OP_NOP: ;
                OP_SET_ROTOR: begin
                    for (int unsigned k = 0; k < NUM_ROTORS; k++) begin
                        if (cmd_data[5*k +: 3] >= 3'(ROTOR_COUNT)) cmd_err = 1'b1;
                        for (int unsigned j = 0; j < k; j++) begin
                            if (cmd_data[5*k +: 3] == cmd_data[5*j +: 3]) cmd_err = 1'b1;
                        end
                        rotor_d[3*k +: 3] = cmd_data[5*k +: 3];
                    end
                end
                OP_SET_RING, OP_SET_GRUND: begin
                    for (int unsigned k = 0; k < NUM_ROTORS; k++) begin
                        if (cmd_data[5*k +: 5] >= 5'(ALPHA)) cmd_err = 1'b1;
                    end
                    if (op == OP_SET_RING) ring_d = cmd_data;
                    else                   grund_d = cmd_data;
                end
                OP_PLUG_ADD: begin
                    if (pa >= 5'(ALPHA) || pb >= 5'(ALPHA) || pa == pb || cnt_q >= 5'(MAX_PAIRS)) begin
                        cmd_err = 1'b1;
                    end else if (pm_q[pa] != pa || pm_q[pb] != pb) begin
                        cmd_err = 1'b1;
                    end else begin
                        pm_d[pa] = pb;
                        pm_d[pb] = pa;
                        cnt_d    = cnt_q + 5'd1;
                    end
                end
                OP_PLUG_DEL: begin
                    if (pa >= 5'(ALPHA)) begin
                        cmd_err = 1'b1;
                    end else if (pm_q[pa] == pa) begin
                        cmd_err = 1'b1;
                    end else begin
                        pm_d[pm_q[pa]] = pm_q[pa];
                        pm_d[pa]       = pa;
                        cnt_d          = cnt_q - 5'd1;
                    end
                end
                OP_PLUG_CLR: begin
                    for (int unsigned i = 0; i < ALPHA; i++) pm_d[i] = 5'(i);
                    cnt_d = FACTORY_PAIRS;
                end
                OP_FACTORY: begin
                    rotor_d = factory_rotor;
                    ring_d  = {NUM_ROTORS{FACTORY_RING}};
                    grund_d = {NUM_ROTORS{FACTORY_GRUND}};
                    for (int unsigned i = 0; i < ALPHA; i++) pm_d[i] = 5'(i);
                    cnt_d   = FACTORY_PAIRS;
                end
                OP_SAVE: begin
                    if (!slot_ok) cmd_err = 1'b1;
                    else          start_copy = 1'b1;
                end
                OP_LOAD: begin
                    if (!slot_ok || !valid_ext[slot]) cmd_err = 1'b1;
                    else                              start_copy = 1'b1;
                end
`ifdef CFG_WRITE_LOCK_EN
                OP_LOCK:   locked_d = 1'b1;
                OP_UNLOCK: locked_d = 1'b0;
`endif
                default: cmd_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = start_copy ? ST_COPY : ST_EXEC;
            ST_EXEC: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_COPY: begin
                busy = 1'b1;
                if (copy_last) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rotor_q     <= factory_rotor;
            ring_q      <= {NUM_ROTORS{FACTORY_RING}};
            grund_q     <= {NUM_ROTORS{FACTORY_GRUND}};
            cnt_q       <= FACTORY_PAIRS;
            for (int unsigned i = 0; i < ALPHA; i++) pm_q[i] <= 5'(i);
            rsp_err_q   <= 1'b0;
            copy_idx_q  <= '0;
            copy_load_q <= 1'b0;
            copy_slot_q <= '0;
`ifdef CFG_WRITE_LOCK_EN
            locked_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_err_q   <= cmd_err;
                copy_idx_q  <= '0;
                copy_load_q <= (op == OP_LOAD);
                copy_slot_q <= slot;
                if (!cmd_err) begin
                    rotor_q  <= rotor_d;
                    ring_q   <= ring_d;
                    grund_q  <= grund_d;
                    cnt_q    <= cnt_d;
                    pm_q     <= pm_d;
`ifdef CFG_WRITE_LOCK_EN
                    locked_q <= locked_d;
`endif
                end
            end else if (state_q == ST_COPY) begin
                // One plug entry per cycle; a LOAD pulls scalars in on the first copy cycle.
                copy_idx_q <= copy_last ? 5'd0 : copy_idx_q + 5'd1;
                if (copy_load_q) begin
                    pm_q[copy_idx_q] <= st_plug;
                    if (copy_first) begin
                        rotor_q <= st_rotor;
                        ring_q  <= st_ring;
                        grund_q <= st_grund;
                        cnt_q   <= st_cnt;
                    end
                end
            end
        end
    end

    assign st_plug_we   = (state_q == ST_COPY) & ~copy_load_q;
    assign st_scalar_we = st_plug_we & copy_first;
    assign st_set_valid = st_plug_we & copy_last;

    config_slot_store #(
        .NUM_ROTORS(NUM_ROTORS),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot       (copy_slot_q),
        .scalar_we  (st_scalar_we),
        .rotor_wdata(rotor_q),
        .ring_wdata (ring_q),
        .grund_wdata(grund_q),
        .cnt_wdata  (cnt_q),
        .rotor_rdata(st_rotor),
        .ring_rdata (st_ring),
        .grund_rdata(st_grund),
        .cnt_rdata  (st_cnt),
        .plug_we    (st_plug_we),
        .plug_idx   (copy_idx_q),
        .plug_wdata (pm_q[copy_idx_q]),
        .plug_rdata (st_plug),
        .set_valid  (st_set_valid),
        .slot_valid (slot_valid)
    );

    always_comb begin
        rotor_sel     = rotor_q;
        ring          = ring_q;
        grund         = grund_q;
        plug_pair_cnt = cnt_q;
        rsp_err       = rsp_valid & rsp_err_q;
        plug_map      = '0;
        for (int unsigned i = 0; i < ALPHA; i++) plug_map[5*i +: 5] = pm_q[i];
    end

endmodule

// File: tb/tb_enigma_config_bank.sv
// Directed, table-driven bench for enigma_config_bank (3 rotors, 4 slots).
module tb_enigma_config_bank;
    localparam int NR = 3;
    localparam int DW = 5 * NR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid, rsp_err, busy, locked;
    logic [3*NR-1:0] rotor_sel;
    logic [DW-1:0] ring, grund;
    logic [129:0]  plug_map;
    logic [4:0]    plug_pair_cnt;

    always #5 clk = ~clk;

    enigma_config_bank #(
        .NUM_ROTORS(NR),
        .NUM_SLOTS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .rotor_sel    (rotor_sel),
        .ring         (ring),
        .grund        (grund),
        .plug_map     (plug_map),
        .plug_pair_cnt(plug_pair_cnt),
        .locked       (locked)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic chk_map(input string name, input int a, input int b);
        logic [4:0] e;
        logic [4:0] g;
        int bad;
        bad = 0;
        for (int i = 0; i < 26; i++) begin
            e = (i == a) ? 5'(b) : (i == b) ? 5'(a) : 5'(i);
            g = plug_map[5*i +: 5];
            if (g !== e) bad++;
        end
        chk(name, 32'(bad), 32'd0);
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [DW-1:0] data,
                          output logic err, output int lat, output int bsy);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) $display("FAIL accept_timeout: op %0d never accepted", op);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        lat = 0;
        bsy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bsy++;
        end while (!rsp_valid && lat < 200);
        err = rsp_err;
    endtask

    typedef struct {
        string         name;
        logic [3:0]    op;
        logic [DW-1:0] data;
        logic          err;
        logic [8:0]    rot;
        logic [DW-1:0] ring;
        logic [DW-1:0] grund;
        logic [4:0]    cnt;
        int            pidx;
        logic [4:0]    pval;
    } vec_t;

    vec_t vecs[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int   lat, bsy, n, first_rsp, second_rsp;
        logic second_err;

        vecs[0]  = '{"nop",        4'd0,  15'h0000, 1'b0, 9'h088, 15'h000, 15'h000, 5'd0, 0,  5'd0};
        vecs[1]  = '{"add_a_e",    4'd4,  15'h0080, 1'b0, 9'h088, 15'h000, 15'h000, 5'd1, 0,  5'd4};
        vecs[2]  = '{"add_e_h",    4'd4,  15'h00E4, 1'b1, 9'h088, 15'h000, 15'h000, 5'd1, 4,  5'd0};
        vecs[3]  = '{"rot_dup",    4'd1,  15'h0821, 1'b1, 9'h088, 15'h000, 15'h000, 5'd1, 0,  5'd4};
        vecs[4]  = '{"rot_430",    4'd1,  15'h0064, 1'b0, 9'h01C, 15'h000, 15'h000, 5'd1, 4,  5'd0};
        vecs[5]  = '{"rot_id5",    4'd1,  15'h0825, 1'b1, 9'h01C, 15'h000, 15'h000, 5'd1, 0,  5'd4};
        vecs[6]  = '{"ring_123",   4'd2,  15'h0C41, 1'b0, 9'h01C, 15'hC41, 15'h000, 5'd1, 0,  5'd4};
        vecs[7]  = '{"grund_25",   4'd3,  15'h0019, 1'b0, 9'h01C, 15'hC41, 15'h019, 5'd1, 0,  5'd4};
        vecs[8]  = '{"grund_26",   4'd3,  15'h6800, 1'b1, 9'h01C, 15'hC41, 15'h019, 5'd1, 0,  5'd4};
        vecs[9]  = '{"del_e",      4'd5,  15'h0004, 1'b0, 9'h01C, 15'hC41, 15'h019, 5'd0, 0,  5'd0};
        vecs[10] = '{"del_again",  4'd5,  15'h0004, 1'b1, 9'h01C, 15'hC41, 15'h019, 5'd0, 4,  5'd4};
        vecs[11] = '{"add_a26",    4'd4,  15'h003A, 1'b1, 9'h01C, 15'hC41, 15'h019, 5'd0, 1,  5'd1};
        vecs[12] = '{"add_same",   4'd4,  15'h0063, 1'b1, 9'h01C, 15'hC41, 15'h019, 5'd0, 3,  5'd3};
        vecs[13] = '{"add_z_y",    4'd4,  15'h0319, 1'b0, 9'h01C, 15'hC41, 15'h019, 5'd1, 25, 5'd24};
        vecs[14] = '{"plug_clr",   4'd6,  15'h0000, 1'b0, 9'h01C, 15'hC41, 15'h019, 5'd0, 25, 5'd25};
        vecs[15] = '{"op12",       4'd12, 15'h0000, 1'b1, 9'h01C, 15'hC41, 15'h019, 5'd0, 24, 5'd24};
        vecs[16] = '{"save_slot5", 4'd8,  15'h0005, 1'b1, 9'h01C, 15'hC41, 15'h019, 5'd0, 0,  5'd0};
        vecs[17] = '{"load_slot3", 4'd9,  15'h0003, 1'b1, 9'h01C, 15'hC41, 15'h019, 5'd0, 0,  5'd0};
        vecs[18] = '{"factory",    4'd7,  15'h0000, 1'b0, 9'h088, 15'h000, 15'h000, 5'd0, 0,  5'd0};

        // reset state
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rotor", 32'(rotor_sel), 32'h088);
        chk("rst_ring", 32'(ring), 32'd0);
        chk("rst_cnt", 32'(plug_pair_cnt), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk_map("rst_map", 0, 0);

        for (int i = 0; i < 19; i++) begin
            do_cmd(vecs[i].op, vecs[i].data, e, lat, bsy);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
            chk({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].err));
            chk({vecs[i].name, "_rot"}, 32'(rotor_sel), 32'(vecs[i].rot));
            chk({vecs[i].name, "_ring"}, 32'(ring), 32'(vecs[i].ring));
            chk({vecs[i].name, "_grund"}, 32'(grund), 32'(vecs[i].grund));
            chk({vecs[i].name, "_cnt"}, 32'(plug_pair_cnt), 32'(vecs[i].cnt));
            chk({vecs[i].name, "_plug"}, 32'(plug_map[5*vecs[i].pidx +: 5]), 32'(vecs[i].pval));
        end

        // thirteen pairs fill the board; a fourteenth is refused
        for (int i = 0; i < 13; i++) begin
            do_cmd(4'd4, DW'(((2*i+1) << 5) | (2*i)), e, lat, bsy);
            if (i == 12) chk("fill_err", 32'(e), 32'd0);
        end
        chk("fill_cnt", 32'(plug_pair_cnt), 32'd13);
        chk("fill_p25", 32'(plug_map[5*25 +: 5]), 32'd24);
        do_cmd(4'd4, 15'h0020, e, lat, bsy);
        chk("add14_err", 32'(e), 32'd1);
        chk("add14_cnt", 32'(plug_pair_cnt), 32'd13);
        do_cmd(4'd6, 15'h0000, e, lat, bsy);
        chk_map("clr_map", 0, 0);

        // save / factory / load round trip
        do_cmd(4'd2, 15'h0C41, e, lat, bsy);
        do_cmd(4'd4, 15'h0080, e, lat, bsy);
        do_cmd(4'd8, 15'h0002, e, lat, bsy);
        chk("save2_lat", 32'(lat), 32'd27);
        chk("save2_busy", 32'(bsy), 32'd26);
        chk("save2_err", 32'(e), 32'd0);
        do_cmd(4'd7, 15'h0000, e, lat, bsy);
        chk("fac_ring", 32'(ring), 32'd0);
        chk_map("fac_map", 0, 0);
        do_cmd(4'd9, 15'h0002, e, lat, bsy);
        chk("load2_lat", 32'(lat), 32'd27);
        chk("load2_busy", 32'(bsy), 32'd26);
        chk("load2_err", 32'(e), 32'd0);
        chk("load2_ring", 32'(ring), 32'hC41);
        chk("load2_rot", 32'(rotor_sel), 32'h088);
        chk("load2_cnt", 32'(plug_pair_cnt), 32'd1);
        chk_map("load2_map", 0, 4);
        do_cmd(4'd9, 15'h0003, e, lat, bsy);
        chk("load3_lat", 32'(lat), 32'd1);
        chk("load3_err", 32'(e), 32'd1);

        // a command offered while busy is held until the copy completes
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd8;
        cmd_data  = 15'h0001;
        @(posedge clk);
        #1;
        cmd_op    = 4'd3;
        cmd_data  = 15'h0005;
        first_rsp = 0;
        second_rsp = 0;
        second_err = 1'b1;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rsp_valid && first_rsp == 0) first_rsp = n;
            else if (rsp_valid && second_rsp == 0) begin
                second_rsp = n;
                second_err = rsp_err;
            end
            if (cmd_valid && cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("held_save_rsp", 32'(first_rsp), 32'd27);
        chk("held_cmd_rsp", 32'(second_rsp), 32'd29);
        chk("held_cmd_err", 32'(second_err), 32'd0);
        chk("held_cmd_grund", 32'(grund), 32'h005);

`ifdef CFG_WRITE_LOCK_EN
        do_cmd(4'd10, 15'h0000, e, lat, bsy);
        chk("lock_err", 32'(e), 32'd0);
        chk("lock_state", 32'(locked), 32'd1);
        do_cmd(4'd2, 15'h0021, e, lat, bsy);
        chk("locked_ring_err", 32'(e), 32'd1);
        chk("locked_ring_val", 32'(ring), 32'hC41);
        do_cmd(4'd11, 15'h0000, e, lat, bsy);
        chk("unlock_err", 32'(e), 32'd0);
        chk("unlock_state", 32'(locked), 32'd0);
        do_cmd(4'd2, 15'h0021, e, lat, bsy);
        chk("unlocked_ring_err", 32'(e), 32'd0);
        chk("unlocked_ring_val", 32'(ring), 32'h021);
`else
        do_cmd(4'd10, 15'h0000, e, lat, bsy);
        chk("lock_err", 32'(e), 32'd1);
        chk("lock_state", 32'(locked), 32'd0);
        do_cmd(4'd11, 15'h0000, e, lat, bsy);
        chk("unlock_err", 32'(e), 32'd1);
`endif

        // reset during a LOAD aborts it silently
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd9;
        cmd_data  = 15'h0002;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        first_rsp = 0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_valid) first_rsp++;
        end
        chk("abort_no_rsp", 32'(first_rsp), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rot", 32'(rotor_sel), 32'h088);
        chk("abort_ring", 32'(ring), 32'd0);
        chk("abort_grund", 32'(grund), 32'd0);
        chk("abort_cnt", 32'(plug_pair_cnt), 32'd0);
        chk_map("abort_map", 0, 0);
        do_cmd(4'd9, 15'h0002, e, lat, bsy);
        chk("abort_slot2_err", 32'(e), 32'd1);
        chk("abort_slot2_lat", 32'(lat), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/enigma_config_bank.md
ENIGMA_CONFIG_BANK -- requirements
Module: enigma_config_bank

Interface
REQ-001 SHALL have parameter NUM_ROTORS, default 3, number of moving rotors (legal 3..4).
REQ-002 SHALL have parameter NUM_SLOTS, default 4, number of saved-configuration slots (legal 1..8).
REQ-003 SHALL use reset rst_n, synchronous, active-low; clock clk.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_op  in  4  opcode: 0 NOP, 1 SET_ROTOR, 2 SET_RING, 3 SET_GRUND, 4 PLUG_ADD, 5 PLUG_DEL, 6 PLUG_CLR, 7 FACTORY, 8 SAVE, 9 LOAD, 10 LOCK, 11 UNLOCK.
REQ-009 cmd_data  in  5*NUM_ROTORS  operand; field k (rotor k, k=0 rightmost) at [5k+4:5k]; rotor ids use low 3 bits of each field; PLUG ops: a=[4:0], b=[9:5]; SAVE/LOAD: slot=[2:0].
REQ-010 rsp_valid  out  1  one-cycle completion pulse per accepted command.
REQ-011 rsp_err  out  1  qualified by rsp_valid; 1 = rejected, live config unchanged.
REQ-012 busy  out  1  high while SAVE/LOAD copy runs.
REQ-013 rotor_sel  out  3*NUM_ROTORS  flat rotor ids (0..4 = I..V).
REQ-014 ring, grund  out  5*NUM_ROTORS each  flat ring settings / Grundstellung.
REQ-015 plug_map  out  130  entry i at [5i+4:5i].
REQ-016 plug_pair_cnt  out  5  current pair count; locked  out  1  write-lock state.

Function
REQ-017 SHALL implement FSM IDLE, EXEC, COPY, RESP; cmd_ready = (state==IDLE) & rst_n.
REQ-018 Single-step ops accepted at cycle T SHALL update outputs and pulse rsp_valid at T+1; NOP responds with rsp_err=0.
REQ-019 SET_ROTOR SHALL err unless every id <5 and all ids distinct.
REQ-020 SET_RING/SET_GRUND SHALL err unless every field <26.
REQ-021 PLUG_ADD SHALL err unless a,b <26, a!=b, plug_map[a]==a, plug_map[b]==b, cnt<13; else set a<->b, cnt+1.
REQ-022 PLUG_DEL SHALL err unless a<26 and plug_map[a]!=a; else restore a and its partner to identity, cnt-1.
REQ-023 PLUG_CLR SHALL set identity map, cnt=0; FACTORY SHALL restore all live config to factory values (rotors 0,1,2[,3]; rings 0; grund 0; identity; cnt 0); slots untouched.
REQ-024 SAVE/LOAD SHALL err in one cycle if slot>=NUM_SLOTS; LOAD also errs if slot never saved.
REQ-025 Valid SAVE/LOAD SHALL enter COPY: scalars (rotors, rings, grund, cnt) copied at T+1, plug entry i copied at T+1+i (i=0..25), busy high T+1..T+26, rsp_valid at T+27.
REQ-026 During LOAD plug_map SHALL be allowed to be transiently inconsistent; consumers SHALL not use it while busy=1.
REQ-027 SAVE SHALL set the slot's valid bit on completion; commands presented while busy SHALL be held, not dropped.
REQ-028 Unknown opcodes SHALL respond rsp_err=1.

Reset
REQ-029 On rst_n=0: state IDLE, live config factory, slot valid bits 0, locked=0, rsp_valid=0, rsp_err=0, busy=0; a SAVE/LOAD in progress SHALL be aborted with no response.

Configuration
REQ-030 Macro CFG_WRITE_LOCK_EN: when defined, LOCK sets locked=1, UNLOCK clears it; while locked ops 1-7 and 9 SHALL err with no change (SAVE, NOP, UNLOCK permitted).
REQ-031 Without CFG_WRITE_LOCK_EN, ops 10/11 SHALL err and locked SHALL be tied 0.

Structure
REQ-032 Package enigma_cfg_pkg SHALL hold opcodes, factory constants, ALPHA=26, MAX_PAIRS=13, ROTOR_COUNT=5.
REQ-033 Slot storage SHALL be sub-module config_slot_store (per-slot scalars, 26x5 plug array, valid bits; one plug-entry write or combinational read per cycle).

Verification
REQ-034 After reset: rotor_sel=0x88 region decodes I,II,III (ids 0,1,2), plug_map identity, cnt=0, cmd_ready=1.
REQ-035 PLUG_ADD a=0,b=4 -> rsp_err=0, plug_map[0]=4, plug_map[4]=0, cnt=1; repeat PLUG_ADD a=4,b=7 -> rsp_err=1, map unchanged.
REQ-036 SET_ROTOR ids 1,1,2 -> rsp_err=1; ids 4,3,0 -> rsp_err=0, rotor_sel updated at T+1.
REQ-037 Configure rings 1,2,3 and pair A-E, SAVE slot 2, FACTORY, LOAD slot 2 -> rsp_valid at T+27, config restored; LOAD slot 3 (unsaved) -> rsp_err=1 at T+1.
REQ-038 rst_n low at T+10 of a LOAD -> no rsp_valid, busy=0, factory config, slot 2 invalid.
REQ-039 With CFG_WRITE_LOCK_EN: LOCK, then SET_RING -> rsp_err=1; UNLOCK, SET_RING -> rsp_err=0; without macro LOCK -> rsp_err=1.
